// File: rtl/jtsbaskt_sndlatch.sv
// jtsbaskt_sndlatch
// Sound-side end of the main-CPU -> sound-CPU command channel (Super Basketball).
// Captures command bytes written by the main 6809 and raises a held interrupt
// to the sound Z80 that stays asserted until the Z80 acknowledges it. Also
// provides the free-running Konami sound timer that the Z80 polls for tempo.
// Both CPUs run from clk through their own clock enables, so every strobe
// is qualified by the matching enable.
//
// Ports
//   rst          sync active-high reset
//   clk          24 MHz system clock
//   main_cen     main CPU bus-cycle enable
//   main_rnw     main CPU read/not-write
//   main_dout    main CPU write data
//   snd_data_cs  main CPU select: command latch
//   snd_on_cs    main CPU select: trigger register (bit 0)
//   snd_cen      Z80 clock enable
//   snd_latch_cs Z80 read strobe for the command latch
//   snd_m1_n     Z80 M1 (active low)
//   snd_iorq_n   Z80 IORQ (active low)
//   snd_int_n    Z80 INT (active low, held until acknowledged)
//   latch_dout   latched command byte
//   timer_dout   {4'b0, timer count}
//   pending      latch written and not yet read by the Z80
module jtsbaskt_sndlatch #(
  parameter int PRESCALE_W = 10
)(
  input  logic       rst,
  input  logic       clk,
  input  logic       main_cen,
  input  logic       main_rnw,
  input  logic [7:0] main_dout,
  input  logic       snd_data_cs,
  input  logic       snd_on_cs,
  input  logic       snd_cen,
  input  logic       snd_latch_cs,
  input  logic       snd_m1_n,
  input  logic       snd_iorq_n,
  output logic       snd_int_n,
  output logic [7:0] latch_dout,
  output logic [7:0] timer_dout,
  output logic       pending
);

  localparam logic [PRESCALE_W-1:0] PRE_ONE = 1;

  logic                  w_wr;
  logic                  w_latch_wr;
  logic                  w_on_wr;
  logic                  w_trig;
  logic                  w_ack;
  logic                  w_consume;
  logic                  w_pre_wrap;

  logic [7:0]            r_latch;
  logic                  r_pending;
  logic                  r_on;
  logic                  r_int_n;
  logic [PRESCALE_W-1:0] r_pre;
  logic [3:0]            r_cnt;

  assign w_wr       = main_cen & ~main_rnw;
  assign w_latch_wr = w_wr & snd_data_cs;
  assign w_on_wr    = w_wr & snd_on_cs;
  // Only a 0->1 transition of the trigger bit fires the interrupt.
  assign w_trig     = w_on_wr & ~r_on & main_dout[0];
  // Interrupt acknowledge cycle: M1 and IORQ low together.
  assign w_ack      = snd_cen & ~snd_m1_n & ~snd_iorq_n;
  assign w_consume  = snd_cen & snd_latch_cs;
  assign w_pre_wrap = snd_cen & (&r_pre);

  // Command latch. A write in the same clk as a Z80 read keeps pending set,
  // so a byte arriving during a read is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_latch   <= 8'd0;
      r_pending <= 1'b0;
    end else begin
      if (w_latch_wr) begin
        r_latch   <= main_dout;
        r_pending <= 1'b1;
      end else if (w_consume) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Trigger edge detector and held interrupt. A trigger beats a coincident
  // acknowledge so a fresh request is not swallowed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_on    <= 1'b0;
      r_int_n <= 1'b1;
    end else begin
      if (w_on_wr) r_on <= main_dout[0];
      if (w_trig)
        r_int_n <= 1'b0;
      else if (w_ack)
        r_int_n <= 1'b1;
    end
  end

  // Sound timer: prescaler wraps every 2^PRESCALE_W snd_cen pulses and
  // advances the 4-bit count on the wrapping pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_cnt <= 4'd0;
    end else if (snd_cen) begin
      r_pre <= r_pre + PRE_ONE;
      if (w_pre_wrap) r_cnt <= r_cnt + 4'd1;
    end
  end

  assign snd_int_n  = r_int_n;
  assign latch_dout = r_latch;
  assign pending    = r_pending;
  assign timer_dout = {4'b0000, r_cnt};

endmodule

// File: doc/jtsbaskt_sndlatch.md
# jtsbaskt_sndlatch

Sound-side end of the main-CPU-to-sound-CPU command channel for Super Basketball. The block captures command bytes written by the main 6809 through its sound-data and sound-trigger strobes. It raises a held, acknowledge-cleared interrupt to the sound Z80 and exposes the latched command to the Z80 read bus. It also provides the free-running Konami sound timer the Z80 polls for tempo. Both CPUs run on the same 24 MHz clk with separate clock enables, so no CDC logic is needed.

## Interface
Parameters:
- PRESCALE_W, 10: width of the snd_cen prescaler; timer advances once per 2^PRESCALE_W snd_cen pulses.

Ports:
- rst  in  1  reset, synchronous, active-high
- clk  in  1  clock, 24 MHz system clock
- main_cen  in  1  main CPU bus-cycle enable (6809 Q-rate)
- main_rnw  in  1  main CPU read/not-write
- main_dout  in  8  main CPU data out
- snd_data_cs  in  1  main CPU selects sound-data latch
- snd_on_cs  in  1  main CPU selects sound-trigger register
- snd_cen  in  1  Z80 clock enable
- snd_latch_cs  in  1  Z80 read of command latch (decoded read strobe)
- snd_m1_n  in  1  Z80 M1, active low
- snd_iorq_n  in  1  Z80 IORQ, active low
- snd_int_n  out  1  Z80 INT, active low, held until acknowledged
- latch_dout  out  8  command byte presented to the Z80 data mux
- timer_dout  out  8  {4'b0, timer count}
- pending  out  1  latch written, not yet read by Z80 (debug/status)

## Operation
- Main write qualifier: wr = main_cen & ~main_rnw.
- Latch: wr & snd_data_cs -> latch_dout <= main_dout; pending <= 1.
- Trigger: wr & snd_on_cs -> on_q <= main_dout[0]; if on_q==0 and main_dout[0]==1, then snd_int_n <= 0. Writes of 1 while on_q==1, and all writes of 0, do not trigger.
- Acknowledge: snd_cen & ~snd_m1_n & ~snd_iorq_n -> snd_int_n <= 1.
- A trigger and an acknowledge in the same clk: trigger wins, snd_int_n stays 0.
- Consumption: snd_cen & snd_latch_cs -> pending <= 0. latch_dout is unchanged; reads are non-destructive.
- A latch write and a consumption in the same clk: the write wins, pending stays 1.
- Overwrite while pending: the new byte replaces the old one with no error and no stall, and pending stays 1.
- Timer:
  - prescaler (PRESCALE_W bits) increments on every snd_cen and wraps at all-ones.
  - On wrap, the 4-bit timer count increments, wrapping 15 -> 0.
  - timer_dout is combinational from the count register.
- Both enables may coincide; main-side and sound-side updates are independent, subject to the priority rules above.

## Timing
- Reset values: snd_int_n=1, latch_dout=0, pending=0, on_q=0, prescaler=0, timer count=0, timer_dout=0.
- Reset asserted mid-operation clears all state on the next clk, including a held interrupt and a pending byte.
- Latch latency: latch_dout and pending update on the first clk edge after the qualifying write cycle (1 clk).
- Interrupt assertion: snd_int_n falls 1 clk after the qualifying rising-bit write.
- Interrupt release: snd_int_n rises 1 clk after the acknowledge sample.
- Strobes outside their cen are ignored: snd_data_cs/snd_on_cs without main_cen, and M1/IORQ or snd_latch_cs without snd_cen.
- Timer period: 16·2^PRESCALE_W snd_cen pulses per full count cycle. The first increment occurs on the 2^PRESCALE_W-th snd_cen after reset.

## Test plan
- Reset, then write 0x5A to snd_data_cs -> latch_dout=0x5A and pending=1 one clk later; a Z80 read with snd_cen -> pending=0, latch_dout still 0x5A.
- snd_on writes 0,1 -> snd_int_n=0 after the second write; a further write of 1 causes no new edge; M1+IORQ low with snd_cen -> snd_int_n=1 next clk and stays 1.
- Trigger write and acknowledge in the same clk while snd_int_n=0 -> snd_int_n remains 0.
- Writes of 0x11 then 0x22 with no intervening read -> latch_dout=0x22, pending=1; a write coinciding with a read -> pending=1.
- PRESCALE_W=2 with snd_cen every clk -> timer_dout goes 0->1 at the 4th pulse and wraps 15->0 at the 64th.
- rst pulse while snd_int_n=0, pending=1 and timer=7 -> all outputs return to reset values one clk later.
